led_status_ctrl: RTL and testbench
==================================

// Module: led_status_ctrl
// PURPOSE
//  Multi-channel LED status driver; next generation of the board-level LED blink logic in Top.
//  Per-channel modes: off, on, blink (period scaled per channel), event-stretch.
//  One shared prescaler drives all channels.
//  Sits in Top between the sys_clk/sys_rst domain and the LED[] pins; SW/KEY-derived controls feed mode/evt.
// PARAMETERS
//  NCH           4           number of LED channels (1..8)
//  TICK_DIV      50_000_000  sys_clk cycles per tick (>=2); 1 s at 50 MHz
//  HALF_TICKS    1           blink half-period of channel 0 in ticks (>=1); channel k uses HALF_TICKS<<k
//  STRETCH_TICKS 2           event-stretch on-time in ticks (>=1)
//  ACTIVE_LOW    0           1: invert led outputs (reset value becomes all-ones)
// PORTS
//  sys_clk  in   1        system clock; all logic on rising edge
//  sys_rst  in   1        synchronous reset, active-high
//  mode     in   2*NCH    per-channel mode, mode[2k+1:2k]: 00 off, 01 on, 10 blink, 11 stretch
//  evt      in   NCH      per-channel event strobe, 1-cycle pulse; used in stretch mode only
//  freeze   in   1        1: prescaler and all tick-driven counters hold; led outputs hold
//  tick     out  1        registered 1-cycle pulse, once per TICK_DIV cycles
//  led      out  NCH      registered LED drive
// BEHAVIOUR
//  Reset (sys_rst=1 at edge)
//   - Clears prescaler, blink counters, blink phases, stretch counters, stored modes.
//   - tick=0; led=0 (all-ones if ACTIVE_LOW).
//   - Reset mid-operation aborts all channels at that edge.
//  Prescaler
//   - pcnt counts 0..TICK_DIV-1 and wraps to 0.
//   - tick=1 for the cycle following pcnt==TICK_DIV-1. First tick: cycle TICK_DIV after reset release.
//   - Width: $clog2(TICK_DIV); no overflow allowed.
//  Per-channel state, registered mode copy mq[k]
//   - Mode change detected as mode[k] != mq[k]; mq[k] <= mode[k] every cycle.
//   - off:     led_int=0. Blink and stretch counters cleared.
//   - on:      led_int=1. Counters cleared.
//   - blink:   on entry bcnt=0, phase=1.
//              Each tick: if bcnt==(HALF_TICKS<<k)-1 then bcnt=0, phase toggles; else bcnt+1.
//              led_int=phase.
//   - stretch: evt[k]=1 loads scnt=STRETCH_TICKS.
//              Otherwise on tick, if scnt!=0, scnt-1.
//              led_int=(scnt!=0).
//              Simultaneous evt and tick: load wins, no decrement. Retrigger while active reloads.
//              evt ignored in other modes. Leaving stretch clears scnt.
//  Output timing
//   - led <= led_int ^ ACTIVE_LOW, registered.
//   - Latency from a mode/evt change at edge t to led change at edge t+1: exactly 1 cycle.
//  freeze=1
//   - pcnt, bcnt, phase and scnt hold; tick=0.
//   - Mode changes still apply to led (on/off immediate); blink/stretch entry init still occurs.
//  Widths
//   - bcnt: $clog2(HALF_TICKS<<(NCH-1)).
//   - scnt: $clog2(STRETCH_TICKS+1).
//   - All counters unsigned, compare-and-wrap; never free-overflow.
// TESTING (NCH=4, TICK_DIV=4, HALF_TICKS=2, STRETCH_TICKS=3, ACTIVE_LOW=0)
//  1. Reset held 3 cycles, mode=0 -> led=4'h0, tick=0. Release -> tick pulses at cycles 4, 8, 12.
//  2. Ch0 blink from reset -> led[0]=1 next cycle, toggles every 8 cycles.
//     Ch1 blink -> toggles every 16 cycles; ch3 -> every 64 cycles.
//  3. Ch2 stretch, evt[2] pulse -> led[2] high next cycle, low after the 3rd following tick.
//     evt coincident with a tick -> that tick not counted.
//  4. Retrigger evt[2] after 2 ticks -> on-time extends to 3 ticks from retrigger.
//     evt[2] in mode off -> led[2] stays 0.
//  5. freeze=1 for 20 cycles during ch0 blink -> no tick, led[0] constant.
//     Release -> phase timing resumes from the held count.
//  6. sys_rst pulsed mid-blink/stretch -> all led=0 next cycle; prescaler restarts (first tick 4 cycles later).
//     ACTIVE_LOW=1 rerun of case 1 -> led=4'hF in reset.

Source files
------------

// File: rtl/led_status_ctrl.sv
// Multi-channel LED status driver: off / on / scaled blink / event-stretch per channel,
// all channels paced by one shared tick prescaler.
module led_status_ctrl #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned HALF_TICKS    = 1,
  parameter int unsigned STRETCH_TICKS = 2,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   evt,
  input  logic             freeze,
  output logic             tick,
  output logic [NCH-1:0]   led
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_STRETCH = 2'b11
  } mode_t;

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BMAX = HALF_TICKS << (NCH - 1);
  localparam int unsigned BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int unsigned SW   = $clog2(STRETCH_TICKS + 1);

  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOAD = SW'(STRETCH_TICKS);

  logic [PW-1:0]  pcnt;
  logic [NCH-1:0] led_int;
  logic           tick_en;

  // A tick already issued still must not advance counters while frozen.
  assign tick_en = tick & ~freeze;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pcnt <= '0;
      tick <= 1'b0;
      led  <= ACTIVE_LOW ? '1 : '0;
    end else begin
      if (!freeze) begin
        pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
      end
      tick <= !freeze && (pcnt == PLAST);
      led  <= led_int ^ {NCH{ACTIVE_LOW}};
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [BW-1:0] BLAST = BW'((HALF_TICKS << k) - 1);

    mode_t         md, mq;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n;
    logic [SW-1:0] scnt, scnt_n;
    logic          lint;

    assign md         = mode_t'(mode[2*k +: 2]);
    assign led_int[k] = lint;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        mq    <= MODE_OFF;
        bcnt  <= '0;
        phase <= 1'b0;
        scnt  <= '0;
      end else begin
        mq    <= md;
        bcnt  <= bcnt_n;
        phase <= phase_n;
        scnt  <= scnt_n;
      end
    end

    // The LED follows the next-state value so a mode/evt change shows after one edge.
    always_comb begin
      bcnt_n  = bcnt;
      phase_n = phase;
      scnt_n  = scnt;
      lint    = 1'b0;
      case (md)
        MODE_OFF: begin
          bcnt_n  = '0;
          phase_n = 1'b0;
          scnt_n  = '0;
          lint    = 1'b0;
        end
        MODE_ON: begin
          bcnt_n  = '0;
          phase_n = 1'b0;
          scnt_n  = '0;
          lint    = 1'b1;
        end
        MODE_BLINK: begin
          scnt_n = '0;
          if (md != mq) begin
            bcnt_n  = '0;
            phase_n = 1'b1;
          end else if (tick_en) begin
            if (bcnt == BLAST) begin
              bcnt_n  = '0;
              phase_n = ~phase;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end
          lint = phase_n;
        end
        MODE_STRETCH: begin
          bcnt_n  = '0;
          phase_n = 1'b0;
          if (evt[k] && !freeze) begin
            scnt_n = SLOAD;
          end else if (md != mq) begin
            scnt_n = '0;
          end else if (tick_en && (scnt != '0)) begin
            scnt_n = scnt - 1'b1;
          end
          lint = (scnt_n != '0);
        end
        default: begin
          bcnt_n  = '0;
          phase_n = 1'b0;
          scnt_n  = '0;
          lint    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl (NCH=4, TICK_DIV=4, HALF_TICKS=2, STRETCH_TICKS=3),
// with a second ACTIVE_LOW instance sharing the stimulus.
module tb_led_status_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mode;
  logic [3:0] evt;
  logic       freeze;
  logic       tick, tick_al;
  logic [3:0] led, led_al;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .NCH(4), .TICK_DIV(4), .HALF_TICKS(2), .STRETCH_TICKS(3), .ACTIVE_LOW(1'b0)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .mode(mode), .evt(evt), .freeze(freeze),
    .tick(tick), .led(led)
  );

  led_status_ctrl #(
    .NCH(4), .TICK_DIV(4), .HALF_TICKS(2), .STRETCH_TICKS(3), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .sys_clk(clk), .sys_rst(rst), .mode(mode), .evt(evt), .freeze(freeze),
    .tick(tick_al), .led(led_al)
  );

  typedef struct {
    logic       rst;
    logic [7:0] mode;
    logic       tick;
    logic [3:0] led;
    logic [3:0] led_al;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] m);
    rst    = 1'b1;
    mode   = m;
    evt    = '0;
    freeze = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    logic e0, e1, e2, e3, et;

    rst    = 1'b1;
    mode   = '0;
    evt    = '0;
    freeze = 1'b0;

    // Reset, prescaler cadence, on/off latency on both polarities.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 8'h00, 1'b0, 4'h0, 4'hF});
    for (int n = 1; n <= 12; n++)
      tbl.push_back('{1'b0, 8'h00, (n % 4 == 0), 4'h0, 4'hF});
    tbl.push_back('{1'b0, 8'h04, 1'b0, 4'h2, 4'hD});
    tbl.push_back('{1'b0, 8'h04, 1'b0, 4'h2, 4'hD});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 4'h0, 4'hF});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 4'h0, 4'hF});

    foreach (tbl[i]) begin
      rst  = tbl[i].rst;
      mode = tbl[i].mode;
      step();
      check($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
      check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
      check($sformatf("tbl%0d_led_al", i), 32'(led_al), 32'(tbl[i].led_al));
      check($sformatf("tbl%0d_tick_al", i), 32'(tick_al), 32'(tbl[i].tick));
    end

    // Blink on ch0/ch1/ch3 from reset: half periods 8, 16, 64 cycles.
    do_reset(8'h8A);
    for (int n = 1; n <= 140; n++) begin
      step();
      e0 = (((n - 1) / 8) % 2) == 0;
      e1 = (((n - 1) / 16) % 2) == 0;
      e3 = (((n - 1) / 64) % 2) == 0;
      check($sformatf("blink_led_n%0d", n), 32'(led), 32'({e3, 1'b0, e1, e0}));
      check($sformatf("blink_tick_n%0d", n), 32'(tick), 32'(n % 4 == 0));
    end

    // Stretch on ch2: plain, tick-coincident, retrigger, then evt while off.
    do_reset(8'h30);
    for (int n = 1; n <= 66; n++) begin
      evt  = (n == 6 || n == 21 || n == 38 || n == 46 || n == 62) ? 4'h4 : 4'h0;
      mode = (n >= 60) ? 8'h00 : 8'h30;
      step();
      e2 = (n >= 6 && n <= 16) || (n >= 21 && n <= 32) || (n >= 38 && n <= 56);
      check($sformatf("stretch_led_n%0d", n), 32'(led), 32'({1'b0, e2, 2'b00}));
    end
    evt = '0;

    // Freeze for 20 edges mid-blink; schedule resumes shifted by 20.
    do_reset(8'h02);
    for (int n = 1; n <= 50; n++) begin
      freeze = (n >= 11 && n <= 30);
      step();
      if (n <= 10) begin
        e0 = (((n - 1) / 8) % 2) == 0;
        et = (n % 4 == 0);
      end else if (n <= 30) begin
        e0 = 1'b0;
        et = 1'b0;
      end else begin
        e0 = (((n - 21) / 8) % 2) == 0;
        et = ((n - 20) % 4 == 0);
      end
      check($sformatf("freeze_led_n%0d", n), 32'(led), 32'({3'b000, e0}));
      check($sformatf("freeze_tick_n%0d", n), 32'(tick), 32'(et));
    end
    freeze = 1'b0;

    // Reset pulse mid-operation, then prescaler and blink restart.
    do_reset(8'h32);
    for (int n = 1; n <= 9; n++) begin
      evt = (n == 6) ? 4'h4 : 4'h0;
      step();
    end
    evt = '0;
    check("pre_rst_led", 32'(led), 32'h4);
    rst = 1'b1;
    step();
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_tick", 32'(tick), 32'h0);
    check("mid_rst_led_al", 32'(led_al), 32'hF);
    rst = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      step();
      check($sformatf("post_rst_tick_m%0d", m), 32'(tick), 32'(m % 4 == 0));
      check($sformatf("post_rst_led_m%0d", m), 32'(led), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
